multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle RV32I decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback. Both instruction and data traffic share one memory port with a ready handshake. Optional M-extension support adds a stall handshake to an external mul/div unit, and a wait-limit watchdog traps on hung handshakes. It sits between the instruction register and the shared-memory datapath, and drives the same control vocabulary as the single-cycle unit plus sequencing strobes.

Parameters:
ENABLE_M, 1, 1 = decode R-type with funct7=0000001 as mul/div; 0 = treat it as illegal
ENABLE_FENCE, 1, 1 = opcode 0001111 executes as a 3-cycle NOP; 0 = illegal
WAIT_LIMIT, 16, max cycles spent waiting in FETCH/MEM/MULDIV before TRAP; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  from instruction register; stable from DECODE onward
funct7_0  in  1  instr[25]; M-extension select
mem_ready  in  1  shared-memory access complete this cycle
muldiv_done  in  1  mul/div result valid this cycle
pc_write  out  1  load PC from pc_src mux
pc_src  out  2  00=PC+4, 01=branch target (gated by datapath compare), 10=JAL/JALR target
branch  out  1  PC write conditional on compare
ir_write  out  1  latch instruction and old PC
i_or_d  out  1  0=address from PC, 1=address from ALU result
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register-file write
mem_to_reg  out  2  00=ALU, 01=memory data, 10=old PC+4
alu_src  out  1  0=rs2, 1=imm
alu_pc  out  1  ALU src1 = old PC
imm_type  out  3  000=I, 001=S, 010=B, 011=U, 100=J
alu_op  out  2  same encoding as the single-cycle unit
muldiv_start  out  1  one-cycle start pulse
illegal  out  1  sticky: illegal opcode
timeout  out  1  sticky: watchdog expired
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULDIV=5, TRAP=6

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - state←FETCH, wait counter←0, illegal←0, timeout←0.
  - While rst is high, all control outputs are forced to 0.
  - Reset mid-instruction abandons the instruction with no reg, mem or PC write; FETCH is entered the cycle after rst drops.
- Outputs are combinational from the state register and opcode. Defaults are all 0 with alu_op=10.
- FETCH:
  - mem_read=1, i_or_d=0, held until mem_ready.
  - On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=00, then →DECODE.
- DECODE:
  - Drives imm_type for opcode.
  - Illegal opcode, or a disabled extension: set illegal, →TRAP.
  - Otherwise →EXEC.
- EXEC:
  - R-type: alu_op=10 →WB. If ENABLE_M and funct7_0=1: muldiv_start=1 →MULDIV.
  - OP-IMM: alu_src=1, alu_op=11 →WB.
  - LUI: alu_src=1, alu_op=00 →WB.
  - AUIPC: alu_pc=1, alu_src=1, alu_op=00 →WB.
  - LOAD/STORE: alu_src=1, alu_op=00 →MEM.
  - BRANCH: branch=1, pc_write=1, pc_src=01, alu_op=01 →FETCH.
  - JAL/JALR: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=10 →FETCH. JALR also sets alu_src=1.
  - FENCE: →FETCH.
- MEM:
  - i_or_d=1; mem_read (LOAD) or mem_write (STORE) held until mem_ready.
  - On mem_ready: LOAD →WB, STORE →FETCH.
- MULDIV: hold until muldiv_done, then →WB.
- WB: reg_write=1, mem_to_reg=01 for LOAD else 00, →FETCH.
- Wait counter:
  - Increments each cycle in FETCH/MEM/MULDIV without the awaited ready.
  - Cleared on every state change.
  - When it reaches WAIT_LIMIT with ready still low: set timeout, →TRAP.
  - Ready arriving on the limit cycle wins.
- TRAP: all strobes 0; held until rst. illegal and timeout stay sticky.
- Cycle counts with zero-wait memory: R/I/LUI/AUIPC 4, LOAD 5, STORE 4, BRANCH/JAL/JALR/FENCE 3, MUL 4+N.

Test Plan:
- ADD (0110011), mem_ready always 1 → state 0,1,2,4,0. reg_write only in WB, pc_write in FETCH cycle 0; 4 cycles total.
- LW with mem_ready low for 2 cycles in MEM → mem_read,i_or_d=1 held 3 cycles, then WB with mem_to_reg=01; 7 cycles total.
- MUL (funct7_0=1), muldiv_done after 3 cycles → single muldiv_start pulse in EXEC, MULDIV 3 cycles, then WB. With ENABLE_M=0, the same instruction sets illegal=1, state=6.
- Opcode 1111111 → illegal=1 after DECODE; state stays 6 and outputs 0 for 20 cycles; rst clears both.
- mem_ready stuck 0 in FETCH, WAIT_LIMIT=16 → timeout=1, state=6 after 16 wait cycles. Ready on cycle 16 → normal DECODE, timeout=0.
- rst asserted in MEM of SW → no mem_write after that edge; FETCH one cycle after rst deasserts.

Source files
------------

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle RV32I control sequencer. Steps each instruction
//               through FETCH / DECODE / EXEC / MEM / WB over a single shared
//               memory port, with an optional mul/div stall state and a
//               wait-limit watchdog that traps on hung handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int ENABLE_M     = 1,
  parameter int ENABLE_FENCE = 1,
  parameter int WAIT_LIMIT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       funct7_0,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       branch,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic       alu_pc,
  output logic [2:0] imm_type,
  output logic [1:0] alu_op,
  output logic       muldiv_start,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  // Sequencer states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MULDIV = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Control field encodings
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_R     = 2'b10;
  localparam logic [1:0] ALU_I     = 2'b11;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_illegal;
  logic       r_timeout;
  logic       w_legal;
  logic       w_muldiv;
  logic       w_wait_state;
  logic       w_ready;
  logic       w_expired;
  logic       w_state_change;

  // Opcode legality, taking the optional extensions into account
  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OP_R:      w_legal = (funct7_0 == 1'b0) || (ENABLE_M != 0);
      OP_FENCE:  w_legal = (ENABLE_FENCE != 0);
      OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR:
                 w_legal = 1'b1;
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_muldiv = (ENABLE_M != 0) && (opcode == OP_R) && funct7_0;

  // Handshake states and the ready each one is waiting for
  always_comb begin
    w_wait_state = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_wait_state = 1'b1;
        w_ready      = mem_ready;
      end
      S_MEM: begin
        w_wait_state = 1'b1;
        w_ready      = mem_ready;
      end
      S_MULDIV: begin
        w_wait_state = 1'b1;
        w_ready      = muldiv_done;
      end
      default: begin
        w_wait_state = 1'b0;
        w_ready      = 1'b0;
      end
    endcase
  end

  assign w_state_change = (w_next_state != r_state);

  // The watchdog counts stalled cycles; once the count has reached the limit,
  // a further cycle without ready traps. A ready seen on that cycle still wins.
  generate
    if (WAIT_LIMIT > 0) begin : g_watchdog
      localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
      logic [CNT_W-1:0] r_wait_cnt;

      // Stall counter: cleared on reset and on every state change
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wait_cnt <= '0;
        end else if (w_state_change) begin
          r_wait_cnt <= '0;
        end else if (w_wait_state && !w_ready) begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
      end

      assign w_expired = w_wait_state && !w_ready &&
                         (r_wait_cnt == CNT_W'(WAIT_LIMIT));
    end else begin : g_no_watchdog
      assign w_expired = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_DECODE) && !w_legal) begin
        r_illegal <= 1'b1;
      end
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_expired) begin
          w_next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        w_next_state = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_R:                     w_next_state = w_muldiv ? S_MULDIV : S_WB;
          OP_IMM, OP_LUI, OP_AUIPC: w_next_state = S_WB;
          OP_LOAD, OP_STORE:        w_next_state = S_MEM;
          default:                  w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          w_next_state = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end else if (w_expired) begin
          w_next_state = S_TRAP;
        end
      end
      S_MULDIV: begin
        if (muldiv_done) begin
          w_next_state = S_WB;
        end else if (w_expired) begin
          w_next_state = S_TRAP;
        end
      end
      S_WB:    w_next_state = S_FETCH;
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Control outputs decoded from the current state and opcode
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    branch       = 1'b0;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = WB_ALU;
    alu_src      = 1'b0;
    alu_pc       = 1'b0;
    imm_type     = IMM_I;
    alu_op       = ALU_R;
    muldiv_start = 1'b0;
    illegal      = r_illegal;
    timeout      = r_timeout;

    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_STORE:         imm_type = IMM_S;
          OP_BRANCH:        imm_type = IMM_B;
          OP_LUI, OP_AUIPC: imm_type = IMM_U;
          OP_JAL:           imm_type = IMM_J;
          default:          imm_type = IMM_I;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_op       = ALU_R;
            muldiv_start = w_muldiv;
          end
          OP_IMM: begin
            alu_src = 1'b1;
            alu_op  = ALU_I;
          end
          OP_LUI, OP_LOAD, OP_STORE: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
          end
          OP_AUIPC: begin
            alu_pc  = 1'b1;
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
          end
          OP_BRANCH: begin
            branch   = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_BRANCH;
            alu_op   = ALU_BR;
          end
          OP_JAL, OP_JALR: begin
            reg_write  = 1'b1;
            mem_to_reg = WB_PC4;
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            alu_src    = (opcode == OP_JALR);
          end
          default: begin
            alu_op = ALU_R;
          end
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
      end
      default: begin
        // MULDIV and TRAP drive no strobes
        alu_op = ALU_R;
      end
    endcase

    // Reset overrides everything so an abandoned instruction writes nothing
    if (rst) begin
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      branch       = 1'b0;
      ir_write     = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      mem_to_reg   = 2'b00;
      alu_src      = 1'b0;
      alu_pc       = 1'b0;
      imm_type     = 3'b000;
      alu_op       = 2'b00;
      muldiv_start = 1'b0;
      illegal      = 1'b0;
      timeout      = 1'b0;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Table-driven cycle-by-cycle bench for the multi-cycle control
//               unit. Each row is one clock of stimulus plus the expected
//               state and control word; rows are queued when driven and popped
//               by a monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  typedef logic [20:0] ctl_t;

  typedef struct {
    logic       alt;
    logic       rst;
    logic [6:0] op;
    logic       f7;
    logic       mr;
    logic       md;
    logic [2:0] st;
    ctl_t       ctl;
    string      tag;
  } vec_t;

  // Control word bit positions:
  // {pc_write, pc_src[1:0], branch, ir_write, i_or_d, mem_read, mem_write,
  //  reg_write, mem_to_reg[1:0], alu_src, alu_pc, imm_type[2:0], alu_op[1:0],
  //  muldiv_start, illegal, timeout}
  localparam ctl_t PCW     = 21'(1) << 20;
  localparam ctl_t PCS_BR  = 21'(1) << 18;
  localparam ctl_t PCS_J   = 21'(2) << 18;
  localparam ctl_t BR      = 21'(1) << 17;
  localparam ctl_t IRW     = 21'(1) << 16;
  localparam ctl_t IOD     = 21'(1) << 15;
  localparam ctl_t MRD     = 21'(1) << 14;
  localparam ctl_t MWR     = 21'(1) << 13;
  localparam ctl_t RGW     = 21'(1) << 12;
  localparam ctl_t MTR_MEM = 21'(1) << 10;
  localparam ctl_t MTR_PC  = 21'(2) << 10;
  localparam ctl_t ASRC    = 21'(1) << 9;
  localparam ctl_t APC     = 21'(1) << 8;
  localparam ctl_t IMM_S   = 21'(1) << 5;
  localparam ctl_t IMM_B   = 21'(2) << 5;
  localparam ctl_t IMM_U   = 21'(3) << 5;
  localparam ctl_t IMM_J   = 21'(4) << 5;
  localparam ctl_t AOP_BR  = 21'(1) << 3;
  localparam ctl_t AOP_R   = 21'(2) << 3;
  localparam ctl_t AOP_I   = 21'(3) << 3;
  localparam ctl_t MDS     = 21'(1) << 2;
  localparam ctl_t ILL     = 21'(1) << 1;
  localparam ctl_t TMO     = 21'(1);
  localparam ctl_t NONE    = 21'(0);

  localparam ctl_t F_OK    = MRD | IRW | PCW | AOP_R;
  localparam ctl_t F_WAIT  = MRD | AOP_R;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_X = 3'd5;
  localparam logic [2:0] ST_T = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       funct7_0;
  logic       mem_ready;
  logic       muldiv_done;

  logic       a_pc_write, a_branch, a_ir_write, a_i_or_d, a_mem_read, a_mem_write;
  logic       a_reg_write, a_alu_src, a_alu_pc, a_muldiv_start, a_illegal, a_timeout;
  logic [1:0] a_pc_src, a_mem_to_reg, a_alu_op;
  logic [2:0] a_imm_type, a_state;

  logic       b_pc_write, b_branch, b_ir_write, b_i_or_d, b_mem_read, b_mem_write;
  logic       b_reg_write, b_alu_src, b_alu_pc, b_muldiv_start, b_illegal, b_timeout;
  logic [1:0] b_pc_src, b_mem_to_reg, b_alu_op;
  logic [2:0] b_imm_type, b_state;

  ctl_t a_ctl;
  ctl_t b_ctl;

  assign a_ctl = {a_pc_write, a_pc_src, a_branch, a_ir_write, a_i_or_d, a_mem_read,
                  a_mem_write, a_reg_write, a_mem_to_reg, a_alu_src, a_alu_pc,
                  a_imm_type, a_alu_op, a_muldiv_start, a_illegal, a_timeout};
  assign b_ctl = {b_pc_write, b_pc_src, b_branch, b_ir_write, b_i_or_d, b_mem_read,
                  b_mem_write, b_reg_write, b_mem_to_reg, b_alu_src, b_alu_pc,
                  b_imm_type, b_alu_op, b_muldiv_start, b_illegal, b_timeout};

  multicycle_control_unit #(
    .ENABLE_M    (1),
    .ENABLE_FENCE(1),
    .WAIT_LIMIT  (16)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct7_0(funct7_0),
    .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .pc_write(a_pc_write), .pc_src(a_pc_src), .branch(a_branch),
    .ir_write(a_ir_write), .i_or_d(a_i_or_d), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .reg_write(a_reg_write), .mem_to_reg(a_mem_to_reg),
    .alu_src(a_alu_src), .alu_pc(a_alu_pc), .imm_type(a_imm_type),
    .alu_op(a_alu_op), .muldiv_start(a_muldiv_start), .illegal(a_illegal),
    .timeout(a_timeout), .state(a_state)
  );

  // Second instance: extensions disabled, watchdog off
  multicycle_control_unit #(
    .ENABLE_M    (0),
    .ENABLE_FENCE(0),
    .WAIT_LIMIT  (0)
  ) dut_alt (
    .clk(clk), .rst(rst), .opcode(opcode), .funct7_0(funct7_0),
    .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .pc_write(b_pc_write), .pc_src(b_pc_src), .branch(b_branch),
    .ir_write(b_ir_write), .i_or_d(b_i_or_d), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg),
    .alu_src(b_alu_src), .alu_pc(b_alu_pc), .imm_type(b_imm_type),
    .alu_op(b_alu_op), .muldiv_start(b_muldiv_start), .illegal(b_illegal),
    .timeout(b_timeout), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t  vecs[$];
  vec_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "";
  logic  cur_alt = 1'b0;

  function automatic void add(logic r, logic [6:0] op, logic f7, logic mr, logic md,
                              logic [2:0] st, ctl_t c);
    vec_t v;
    v.alt = cur_alt;
    v.rst = r;
    v.op  = op;
    v.f7  = f7;
    v.mr  = mr;
    v.md  = md;
    v.st  = st;
    v.ctl = c;
    v.tag = cur_tag;
    vecs.push_back(v);
  endfunction

  function automatic void row(logic [6:0] op, logic f7, logic mr, logic md,
                              logic [2:0] st, ctl_t c);
    add(1'b0, op, f7, mr, md, st, c);
  endfunction

  function automatic void fetch_ok(logic [6:0] op, logic f7);
    row(op, f7, 1'b1, 1'b0, ST_F, F_OK);
  endfunction

  // Monitor: compare the oldest queued expectation against the selected DUT
  vec_t       mon_e;
  logic [2:0] mon_st;
  ctl_t       mon_ctl;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.alt) begin
        mon_st  = b_state;
        mon_ctl = b_ctl;
      end else begin
        mon_st  = a_state;
        mon_ctl = a_ctl;
      end
      checks++;
      if (mon_st !== mon_e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", mon_e.tag, mon_st, mon_e.st);
      end
      checks++;
      if (mon_ctl !== mon_e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %021b expected %021b", mon_e.tag, mon_ctl, mon_e.ctl);
      end
    end
  end

  initial begin
    rst         = 1'b1;
    opcode      = OP_R;
    funct7_0    = 1'b0;
    mem_ready   = 1'b0;
    muldiv_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---------------- main instance ----------------
    cur_tag = "reset";
    add(1'b1, OP_R, 1'b0, 1'b1, 1'b0, ST_F, NONE);

    cur_tag = "add";
    fetch_ok(OP_R, 1'b0);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_E, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    cur_tag = "lw";
    fetch_ok(OP_LOAD, 1'b0);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_E, ASRC);
    row(OP_LOAD, 1'b0, 1'b0, 1'b0, ST_M, IOD | MRD | AOP_R);
    row(OP_LOAD, 1'b0, 1'b0, 1'b0, ST_M, IOD | MRD | AOP_R);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_M, IOD | MRD | AOP_R);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_W, RGW | MTR_MEM | AOP_R);

    cur_tag = "mul";
    fetch_ok(OP_R, 1'b1);
    row(OP_R, 1'b1, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b0, ST_E, MDS | AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b0, ST_X, AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b0, ST_X, AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b1, ST_X, AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    cur_tag = "opimm";
    fetch_ok(OP_IMM, 1'b0);
    row(OP_IMM, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_IMM, 1'b0, 1'b1, 1'b0, ST_E, ASRC | AOP_I);
    row(OP_IMM, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    cur_tag = "lui";
    fetch_ok(OP_LUI, 1'b0);
    row(OP_LUI, 1'b0, 1'b1, 1'b0, ST_D, IMM_U | AOP_R);
    row(OP_LUI, 1'b0, 1'b1, 1'b0, ST_E, ASRC);
    row(OP_LUI, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    cur_tag = "auipc";
    fetch_ok(OP_AUIPC, 1'b0);
    row(OP_AUIPC, 1'b0, 1'b1, 1'b0, ST_D, IMM_U | AOP_R);
    row(OP_AUIPC, 1'b0, 1'b1, 1'b0, ST_E, APC | ASRC);
    row(OP_AUIPC, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    cur_tag = "branch";
    fetch_ok(OP_BRANCH, 1'b0);
    row(OP_BRANCH, 1'b0, 1'b1, 1'b0, ST_D, IMM_B | AOP_R);
    row(OP_BRANCH, 1'b0, 1'b1, 1'b0, ST_E, BR | PCW | PCS_BR | AOP_BR);

    cur_tag = "jal";
    fetch_ok(OP_JAL, 1'b0);
    row(OP_JAL, 1'b0, 1'b1, 1'b0, ST_D, IMM_J | AOP_R);
    row(OP_JAL, 1'b0, 1'b1, 1'b0, ST_E, RGW | MTR_PC | PCW | PCS_J | AOP_R);

    cur_tag = "jalr";
    fetch_ok(OP_JALR, 1'b0);
    row(OP_JALR, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_JALR, 1'b0, 1'b1, 1'b0, ST_E, RGW | MTR_PC | PCW | PCS_J | ASRC | AOP_R);

    cur_tag = "fence";
    fetch_ok(OP_FENCE, 1'b0);
    row(OP_FENCE, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_FENCE, 1'b0, 1'b1, 1'b0, ST_E, AOP_R);

    cur_tag = "sw";
    fetch_ok(OP_STORE, 1'b0);
    row(OP_STORE, 1'b0, 1'b1, 1'b0, ST_D, IMM_S | AOP_R);
    row(OP_STORE, 1'b0, 1'b1, 1'b0, ST_E, ASRC);
    row(OP_STORE, 1'b0, 1'b1, 1'b0, ST_M, IOD | MWR | AOP_R);

    cur_tag = "sw_rst";
    fetch_ok(OP_STORE, 1'b0);
    row(OP_STORE, 1'b0, 1'b1, 1'b0, ST_D, IMM_S | AOP_R);
    row(OP_STORE, 1'b0, 1'b1, 1'b0, ST_E, ASRC);
    row(OP_STORE, 1'b0, 1'b0, 1'b0, ST_M, IOD | MWR | AOP_R);
    add(1'b1, OP_STORE, 1'b0, 1'b0, 1'b0, ST_M, NONE);
    row(OP_STORE, 1'b0, 1'b0, 1'b0, ST_F, F_WAIT);
    fetch_ok(OP_R, 1'b0);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_E, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    // Counter restarts per state: 10 fetch waits then 10 memory waits
    cur_tag = "wait_split";
    for (int i = 0; i < 10; i++) row(OP_LOAD, 1'b0, 1'b0, 1'b0, ST_F, F_WAIT);
    fetch_ok(OP_LOAD, 1'b0);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_E, ASRC);
    for (int i = 0; i < 10; i++) row(OP_LOAD, 1'b0, 1'b0, 1'b0, ST_M, IOD | MRD | AOP_R);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_M, IOD | MRD | AOP_R);
    row(OP_LOAD, 1'b0, 1'b1, 1'b0, ST_W, RGW | MTR_MEM | AOP_R);

    // Ready arrives on the limit cycle (counter == 16): proceeds normally
    cur_tag = "limit_ready";
    for (int i = 0; i < 16; i++) row(OP_R, 1'b0, 1'b0, 1'b0, ST_F, F_WAIT);
    fetch_ok(OP_R, 1'b0);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_E, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    cur_tag = "illegal";
    fetch_ok(OP_BAD, 1'b0);
    row(OP_BAD, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    for (int i = 0; i < 20; i++) row(OP_BAD, 1'b0, 1'b1, 1'b1, ST_T, ILL | AOP_R);
    add(1'b1, OP_BAD, 1'b0, 1'b1, 1'b1, ST_T, NONE);

    // Ready stuck low: 16 counted waits, then the limit cycle traps
    cur_tag = "timeout";
    for (int i = 0; i < 17; i++) row(OP_R, 1'b0, 1'b0, 1'b0, ST_F, F_WAIT);
    for (int i = 0; i < 3; i++)  row(OP_R, 1'b0, 1'b1, 1'b0, ST_T, TMO | AOP_R);
    add(1'b1, OP_R, 1'b0, 1'b1, 1'b0, ST_T, NONE);

    // ---------------- extensions disabled, watchdog off ----------------
    cur_alt = 1'b1;
    cur_tag = "alt_mul";
    fetch_ok(OP_R, 1'b1);
    row(OP_R, 1'b1, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b1, ST_T, ILL | AOP_R);
    row(OP_R, 1'b1, 1'b1, 1'b1, ST_T, ILL | AOP_R);
    add(1'b1, OP_R, 1'b1, 1'b1, 1'b0, ST_T, NONE);

    cur_tag = "alt_fence";
    fetch_ok(OP_FENCE, 1'b0);
    row(OP_FENCE, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_FENCE, 1'b0, 1'b1, 1'b0, ST_T, ILL | AOP_R);
    add(1'b1, OP_FENCE, 1'b0, 1'b1, 1'b0, ST_T, NONE);

    cur_tag = "alt_nowdog";
    for (int i = 0; i < 40; i++) row(OP_R, 1'b0, 1'b0, 1'b0, ST_F, F_WAIT);
    fetch_ok(OP_R, 1'b0);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_D, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_E, AOP_R);
    row(OP_R, 1'b0, 1'b1, 1'b0, ST_W, RGW | AOP_R);

    // Apply rows one clock each; the monitor checks them on the falling edge
    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      opcode      = vecs[i].op;
      funct7_0    = vecs[i].f7;
      mem_ready   = vecs[i].mr;
      muldiv_done = vecs[i].md;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
